// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
// Imported by the target, its interface users and the bench.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_WAIT_STOP
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h39;

endpackage

// File: rtl/i2c_reg_slave_if.sv
// Pin and register-port bundle of the I2C register target.
// slave = the target, master = bus driver plus user register logic.
interface i2c_reg_slave_if;

    logic       I2C_SCL_IN;
    logic       I2C_SDA_IN;
    logic       I2C_SDA_OE;
    logic       REG_WR_EN;
    logic [7:0] REG_WR_ADDR;
    logic [7:0] REG_WR_DATA;
    logic [7:0] REG_RD_ADDR;
    logic [7:0] REG_RD_DATA;
    logic       BUSY;

    modport slave (
        input  I2C_SCL_IN, I2C_SDA_IN, REG_RD_DATA,
        output I2C_SDA_OE, REG_WR_EN, REG_WR_ADDR,
        output REG_WR_DATA, REG_RD_ADDR, BUSY
    );

    modport master (
        output I2C_SCL_IN, I2C_SDA_IN, REG_RD_DATA,
        input  I2C_SDA_OE, REG_WR_EN, REG_WR_ADDR,
        input  REG_WR_DATA, REG_RD_ADDR, BUSY
    );

endinterface

// File: rtl/i2c_in_filter.sv
// Synchronizer, glitch filter and edge detect for one I2C pin.
// The level flips only after FILT_LEN consecutive samples disagree.
module i2c_in_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic i_pin,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [3:0] LIM = 4'(FILT_LEN - 1);

    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_lvl;
    logic       r_prev;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_sync <= 2'b11;
            r_cnt  <= 4'd0;
            r_lvl  <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            r_prev <= r_lvl;
            if (r_sync[1] == r_lvl) begin
                r_cnt <= 4'd0;
            end else if (r_cnt == LIM) begin
                r_lvl <= r_sync[1];
                r_cnt <= 4'd0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_lvl  = r_lvl;
    assign o_rise = r_lvl & ~r_prev;
    assign o_fall = ~r_lvl & r_prev;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C register target: [addr, sub, data...] writes and combined reads.
// Oversamples SCL/SDA on iCLK; never stretches the clock.
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int         FILT_LEN   = 4
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    i2c_reg_slave_if.slave  bus
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .i_pin  (bus.I2C_SCL_IN),
        .o_lvl  (w_scl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .i_pin  (bus.I2C_SDA_IN),
        .o_lvl  (w_sda),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    i2c_state_t r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_ptr, w_ptr_nxt;
    logic       r_oe, w_oe_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_inc, w_inc_nxt;
    logic       r_wr_en, w_wr_en_nxt;
    logic [7:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0] r_wr_data, w_wr_data_nxt;
    logic [7:0] w_byte;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'd0;
            r_ptr     <= 8'd0;
            r_oe      <= 1'b0;
            r_rw      <= 1'b0;
            r_inc     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_oe      <= w_oe_nxt;
            r_rw      <= w_rw_nxt;
            r_inc     <= w_inc_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    // In the ACK states r_oe doubles as the phase: first fall drives, second exits.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_oe_nxt      = r_oe;
        w_rw_nxt      = r_rw;
        w_inc_nxt     = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_byte        = {r_shift[6:0], w_sda};
        if (r_inc) w_ptr_nxt = r_ptr + 8'd1;
        if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_oe_nxt    = 1'b0;
        end else begin
            unique case (r_state)
                ST_ADDR: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        w_rw_nxt    = w_sda;
                        w_state_nxt = (r_shift[6:0] == SLAVE_ADDR)
                                    ? ST_ADDR_ACK : ST_IDLE;
                    end
                end
                ST_ADDR_ACK: if (w_scl_fall) begin
                    if (!r_oe) begin
                        w_oe_nxt = 1'b1;
                    end else if (r_rw) begin
                        w_state_nxt = ST_RDATA;
                        w_shift_nxt = bus.REG_RD_DATA;
                        w_oe_nxt    = ~bus.REG_RD_DATA[7];
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = ST_SUB;
                        w_oe_nxt    = 1'b0;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                ST_SUB: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        w_ptr_nxt   = w_byte;
                        w_state_nxt = ST_SUB_ACK;
                    end
                end
                ST_SUB_ACK, ST_WDATA_ACK: if (w_scl_fall) begin
                    if (!r_oe) begin
                        w_oe_nxt = 1'b1;
                        if (r_state == ST_WDATA_ACK) begin
                            w_wr_en_nxt   = 1'b1;
                            w_wr_addr_nxt = r_ptr;
                            w_wr_data_nxt = r_shift;
                            w_inc_nxt     = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_WDATA;
                        w_oe_nxt    = 1'b0;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                ST_WDATA: if (w_scl_rise) begin
                    w_shift_nxt = w_byte;
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == 4'd7) w_state_nxt = ST_WDATA_ACK;
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = ST_RACK;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_oe_nxt    = ~r_shift[6];
                        end
                    end
                end
                ST_RACK: begin
                    if (w_scl_rise) begin
                        w_inc_nxt = 1'b1;
                        if (w_sda == I2C_NACK) w_state_nxt = ST_WAIT_STOP;
                    end else if (w_scl_fall) begin
                        w_state_nxt = ST_RDATA;
                        w_shift_nxt = bus.REG_RD_DATA;
                        w_oe_nxt    = ~bus.REG_RD_DATA[7];
                        w_cnt_nxt   = 4'd0;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: ;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.I2C_SDA_OE  = r_oe;
        bus.REG_WR_EN   = r_wr_en;
        bus.REG_WR_ADDR = r_wr_addr;
        bus.REG_WR_DATA = r_wr_data;
        bus.REG_RD_ADDR = r_ptr;
        bus.BUSY        = r_state inside {ST_ADDR_ACK, ST_SUB,
                          ST_SUB_ACK, ST_WDATA, ST_WDATA_ACK,
                          ST_RDATA, ST_RACK};
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: writes, bursts, combined reads,
// address mismatch, SCL glitch filtering and mid-transfer reset.
module tb_i2c_reg_slave;
    import i2c_pkg::*;

    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda_m = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    int wr_n = 0;
    int oe_n = 0;
    int busy_n = 0;
    logic [7:0] wa [0:15];
    logic [7:0] wd [0:15];

    i2c_reg_slave_if bus ();

    assign bus.I2C_SCL_IN  = scl;
    assign bus.I2C_SDA_IN  = sda_m & ~bus.I2C_SDA_OE;
    assign bus.REG_RD_DATA = bus.REG_RD_ADDR + 8'h10;

    i2c_reg_slave #(.SLAVE_ADDR(7'h39), .FILT_LEN(4)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.REG_WR_EN) begin
            wa[wr_n[3:0]] <= bus.REG_WR_ADDR;
            wd[wr_n[3:0]] <= bus.REG_WR_DATA;
            wr_n <= wr_n + 1;
        end
        if (bus.I2C_SDA_OE) oe_n <= oe_n + 1;
        if (bus.BUSY) busy_n <= busy_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit slot starts mid-low; g>0 inserts an SCL low pulse mid-high.
    task automatic send_bit(input logic b, input int g, output logic s);
        sda_m = b;
        w(Q);
        scl = 1'b1;
        if (g > 0) begin
            w(8);
            scl = 1'b0;
            w(g);
            scl = 1'b1;
            w(8);
        end else begin
            w(Q);
        end
        s = bus.I2C_SDA_IN;
        w(Q);
        scl = 1'b0;
        w(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int g,
                             output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 7) ? g : 0, s);
        send_bit(1'b1, 0, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 0, s);
            d[i] = s;
        end
        send_bit(mack, 0, s);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        w(Q);
        scl = 1'b1;
        w(Q);
        sda_m = 1'b0;
        w(Q);
        scl = 1'b0;
        w(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        w(Q);
        scl = 1'b1;
        w(Q);
        sda_m = 1'b1;
        w(2 * Q);
    endtask

    initial begin
        logic a0, a1, a2, a3;
        logic [7:0] d0, d1, b;
        int w0, o0, k0;
        w(5);
        rst_n = 1'b1;
        w(5);
        chk("rst_oe", bus.I2C_SDA_OE, 0);
        chk("rst_wr_en", bus.REG_WR_EN, 0);
        chk("rst_wr_addr", bus.REG_WR_ADDR, 0);
        chk("rst_wr_data", bus.REG_WR_DATA, 0);
        chk("rst_rd_addr", bus.REG_RD_ADDR, 0);
        chk("rst_busy", bus.BUSY, 0);

        w0 = wr_n;
        i2c_start();
        send_byte(8'h72, 0, a0);
        send_byte(8'h98, 0, a1);
        send_byte(8'h03, 0, a2);
        chk("wr_ack_addr", a0, I2C_ACK);
        chk("wr_ack_sub", a1, I2C_ACK);
        chk("wr_ack_data", a2, I2C_ACK);
        chk("wr_busy_on", bus.BUSY, 1);
        i2c_stop();
        chk("wr_busy_off", bus.BUSY, 0);
        chk("wr_count", wr_n - w0, 1);
        chk("wr_addr", wa[w0[3:0]], 8'h98);
        chk("wr_data", wd[w0[3:0]], 8'h03);
        chk("wr_ptr", bus.REG_RD_ADDR, 8'h99);

        w0 = wr_n;
        o0 = oe_n;
        k0 = busy_n;
        i2c_start();
        send_byte(8'h70, 0, a0);
        send_byte(8'h98, 0, a1);
        send_byte(8'h03, 0, a2);
        i2c_stop();
        chk("miss_ack", a0, I2C_NACK);
        chk("miss_oe_cycles", oe_n - o0, 0);
        chk("miss_wr_count", wr_n - w0, 0);
        chk("miss_busy_cycles", busy_n - k0, 0);

        w0 = wr_n;
        i2c_start();
        send_byte(8'h72, 0, a0);
        send_byte(8'hFF, 0, a1);
        send_byte(8'h11, 0, a2);
        send_byte(8'h22, 0, a3);
        i2c_stop();
        chk("burst_acks", {a0, a1, a2, a3}, 4'b0000);
        chk("burst_count", wr_n - w0, 2);
        chk("burst_addr0", wa[w0[3:0]], 8'hFF);
        chk("burst_data0", wd[w0[3:0]], 8'h11);
        chk("burst_addr1", wa[4'(w0 + 1)], 8'h00);
        chk("burst_data1", wd[4'(w0 + 1)], 8'h22);
        chk("burst_ptr", bus.REG_RD_ADDR, 8'h01);

        w0 = wr_n;
        i2c_start();
        send_byte(8'h72, 0, a0);
        send_byte(8'h15, 0, a1);
        i2c_start();
        send_byte(8'h73, 0, a2);
        recv_byte(I2C_ACK, d0);
        recv_byte(I2C_NACK, d1);
        chk("rd_acks", {a0, a1, a2}, 3'b000);
        chk("rd_byte0", d0, 8'h25);
        chk("rd_byte1", d1, 8'h26);
        chk("rd_oe_after_nack", bus.I2C_SDA_OE, 0);
        chk("rd_busy_after_nack", bus.BUSY, 0);
        i2c_stop();
        chk("rd_ptr", bus.REG_RD_ADDR, 8'h17);
        chk("rd_no_write", wr_n - w0, 0);

        w0 = wr_n;
        i2c_start();
        send_byte(8'h72, 3, a0);
        send_byte(8'h40, 0, a1);
        send_byte(8'hA5, 0, a2);
        i2c_stop();
        chk("glitch3_acks", {a0, a1, a2}, 3'b000);
        chk("glitch3_count", wr_n - w0, 1);
        chk("glitch3_addr", wa[w0[3:0]], 8'h40);
        chk("glitch3_data", wd[w0[3:0]], 8'hA5);

        w0 = wr_n;
        i2c_start();
        send_byte(8'h72, 4, a0);
        send_byte(8'h40, 0, a1);
        i2c_stop();
        chk("glitch4_nack", a0, I2C_NACK);
        chk("glitch4_count", wr_n - w0, 0);

        w0 = wr_n;
        b = 8'h72;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(b[i], 0, a0);
        chk("arst_oe_before", bus.I2C_SDA_OE, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_oe_async", bus.I2C_SDA_OE, 0);
        w(3);
        scl = 1'b1;
        sda_m = 1'b1;
        w(5);
        rst_n = 1'b1;
        w(10);
        chk("arst_ptr", bus.REG_RD_ADDR, 0);
        chk("arst_busy", bus.BUSY, 0);
        chk("arst_no_write", wr_n - w0, 0);
        i2c_start();
        send_byte(8'h72, 0, a0);
        send_byte(8'h20, 0, a1);
        send_byte(8'h5A, 0, a2);
        i2c_stop();
        chk("arst_acks", {a0, a1, a2}, 3'b000);
        chk("arst_count", wr_n - w0, 1);
        chk("arst_addr", wa[w0[3:0]], 8'h20);
        chk("arst_data", wd[w0[3:0]], 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
